// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, default
// parameters and the three-input majority helper.
package mux_scan_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  localparam int DEFAULT_SELECT_LINES = 2;
  localparam int DEFAULT_DWELL_WIDTH  = 8;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN
  } state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mux_scan_sampler.sv
// Per-channel sample resolver. With MUX_SCAN_MAJORITY_EN defined it votes over
// the last three cycles of a channel; otherwise it passes mux_out straight through.
module mux_scan_sampler
  import mux_scan_pkg::*;
(
`ifdef MUX_SCAN_MAJORITY_EN
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vote_en_i,
  input  logic strobe2_i,
  input  logic strobe1_i,
  input  logic strobe0_i,
`endif
  input  logic mux_out_i,
  output logic bit_o
);

`ifdef MUX_SCAN_MAJORITY_EN
  logic s2_q;
  logic s1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      if (strobe2_i) s2_q <= mux_out_i;
      if (strobe1_i) s1_q <= mux_out_i;
    end
  end

  // The third vote is the live mux output on the channel's final cycle.
  assign bit_o = (vote_en_i && strobe0_i) ? majority3(s2_q, s1_q, mux_out_i) : mux_out_i;
`else
  assign bit_o = mux_out_i;
`endif

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps a downstream mux select through every channel with a programmable dwell
// and assembles the sampled bits. Optional vote filter: MUX_SCAN_MAJORITY_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SELECT_LINES = DEFAULT_SELECT_LINES,
  parameter int DWELL_WIDTH  = DEFAULT_DWELL_WIDTH,
  localparam int N           = 1 << SELECT_LINES
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    continuous_i,
  input  logic [DWELL_WIDTH-1:0]  dwell_i,
  input  logic                    mux_out_i,
  output logic [SELECT_LINES-1:0] select_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [N-1:0]            captured_o,
  output logic                    captured_valid_o
);

  localparam logic [SELECT_LINES-1:0] LAST_SEL = SELECT_LINES'(N - 1);

  state_e                  state_q;
  logic [SELECT_LINES-1:0] sel_q;
  logic [DWELL_WIDTH-1:0]  dwell_q;
  logic [DWELL_WIDTH-1:0]  cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [N-1:0]            captured_q;
  logic                    captured_valid_q;
  logic                    sample_d;

  mux_scan_sampler u_sampler (
`ifdef MUX_SCAN_MAJORITY_EN
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .vote_en_i (dwell_q >= DWELL_WIDTH'(2)),
    .strobe2_i ((state_q == S_SCAN) && (cnt_q == DWELL_WIDTH'(2))),
    .strobe1_i ((state_q == S_SCAN) && (cnt_q == DWELL_WIDTH'(1))),
    .strobe0_i ((state_q == S_SCAN) && (cnt_q == '0)),
`endif
    .mux_out_i (mux_out_i),
    .bit_o     (sample_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= S_IDLE;
      sel_q            <= '0;
      dwell_q          <= '0;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      captured_q       <= '0;
      captured_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_q          <= S_SCAN;
            busy_q           <= 1'b1;
            dwell_q          <= dwell_i;
            cnt_q            <= dwell_i;
            sel_q            <= '0;
            captured_valid_q <= 1'b0;
          end
        end
        S_SCAN: begin
          // Abort wins over everything, including a completing last channel.
          if (abort_i) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            sel_q            <= '0;
            cnt_q            <= '0;
            captured_valid_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q            <= cnt_q - 1'b1;
            captured_valid_q <= 1'b0;
          end else begin
            captured_q[sel_q] <= sample_d;
            cnt_q             <= dwell_q;
            if (sel_q != LAST_SEL) begin
              sel_q            <= sel_q + 1'b1;
              captured_valid_q <= 1'b0;
            end else begin
              done_q           <= 1'b1;
              captured_valid_q <= 1'b1;
              sel_q            <= '0;
              if (!continuous_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign select_o         = sel_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign captured_o       = captured_q;
  assign captured_valid_o = captured_valid_q;

endmodule
